// File: rtl/ff_ctrl_pkg.sv
// Shared definitions for the flip-flop RAM FIFO controller: default widths
// and the round-robin arbitration side encoding.
package ff_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 3;

    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_e;

endpackage : ff_ctrl_pkg

// File: rtl/ff_ptr.sv
// Wrap-around pointer register; advances by one on inc and wraps at 2**WIDTH.
module ff_ptr #(
    parameter int unsigned WIDTH = ff_ctrl_pkg::DEF_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule : ff_ptr

// File: rtl/ff_ctrl.sv
// Valid/ready FIFO controller in front of a single-port flip-flop RAM,
// issuing at most one RAM access per cycle with round-robin arbitration.
module ff_ctrl
    import ff_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ram_cs,
    output logic                  ram_rws,
    output logic [ADDR_WIDTH-1:0] ram_wptr,
    output logic [ADDR_WIDTH-1:0] ram_rptr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [ADDR_WIDTH:0] DEPTH_OCC = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   occ;
    prio_e                 prio;
    logic                  wr_req;
    logic                  rd_req;
    logic                  wr_grant;
    logic                  rd_grant;

    assign wr_req = in_valid && (occ < DEPTH_OCC);
    assign rd_req = (occ != '0) && (!out_valid || out_ready);

    // Grants are held off during reset so the RAM sees no access.
    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (rst_n) begin
            if (wr_req && rd_req) begin
                wr_grant = (prio == PRIO_WR);
                rd_grant = (prio == PRIO_RD);
            end else begin
                wr_grant = wr_req;
                rd_grant = rd_req;
            end
        end
    end

    ff_ptr #(.WIDTH(ADDR_WIDTH)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_grant),
        .ptr   (wptr)
    );

    ff_ptr #(.WIDTH(ADDR_WIDTH)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_grant),
        .ptr   (rptr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ  <= '0;
            prio <= PRIO_WR;
        end else begin
            if (wr_grant) begin
                occ  <= occ + 1'b1;
                prio <= PRIO_RD;
            end else if (rd_grant) begin
                occ  <= occ - 1'b1;
                prio <= PRIO_WR;
            end
        end
    end

    // A read refills the output stage even while it is being consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (rd_grant) begin
            out_valid <= 1'b1;
            out_data  <= ram_rdata;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign in_ready  = wr_grant;
    assign ram_cs    = wr_grant | rd_grant;
    assign ram_rws   = wr_grant;
    assign ram_wptr  = wptr;
    assign ram_rptr  = rptr;
    assign ram_wdata = in_data;

    assign count = occ + {{ADDR_WIDTH{1'b0}}, out_valid};
    assign full  = (occ == DEPTH_OCC);
    assign empty = (count == '0);

endmodule : ff_ctrl

// File: tb/tb_ff_ctrl.sv
// Directed bench for ff_ctrl with a behavioural flip-flop RAM attached.
module tb_ff_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ram_cs;
    logic       ram_rws;
    logic [2:0] ram_wptr;
    logic [2:0] ram_rptr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem [8];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs && ram_rws) mem[ram_wptr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_rptr];

    ff_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ram_cs    (ram_cs),
        .ram_rws   (ram_rws),
        .ram_wptr  (ram_wptr),
        .ram_rptr  (ram_rptr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_cmp++; if (ram_cs !== 1'b0) begin n_err++; $display("FAIL reset_ram_cs got %b want 0", ram_cs); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        #1;
        n_cmp++; if ({ram_cs, ram_rws, in_ready} !== 3'b111) begin n_err++; $display("FAIL single_c0_write got cs/rws/rdy=%b want 111", {ram_cs, ram_rws, in_ready}); end
        n_cmp++; if (ram_wptr !== 3'd0) begin n_err++; $display("FAIL single_c0_wptr got %0d want 0", ram_wptr); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        n_cmp++; if ({ram_cs, ram_rws} !== 2'b10) begin n_err++; $display("FAIL single_c1_read got cs/rws=%b want 10", {ram_cs, ram_rws}); end
        n_cmp++; if (ram_rptr !== 3'd0) begin n_err++; $display("FAIL single_c1_rptr got %0d want 0", ram_rptr); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_err++; $display("FAIL single_c2_out got v=%b d=%h want v=1 d=a5", out_valid, out_data); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_c2_count got %0d want 1", count); end
        @(posedge clk); #1;
        n_cmp++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained got empty=%b v=%b want 1/0", empty, out_valid); end
    endtask

    task automatic test_fill();
        int sent = 0;
        int got = 0;
        logic [7:0] exp_d;
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            in_valid = (sent < 10);
            in_data = 8'(sent + 1);
            #1;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b1; in_data = 8'h0A;
        #1;
        n_cmp++; if (sent !== 9) begin n_err++; $display("FAIL fill_accepted got %0d want 9", sent); end
        n_cmp++; if (count !== 4'd9) begin n_err++; $display("FAIL fill_count got %0d want 9", count); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 9; c++) begin
            #1;
            if (out_valid) begin
                exp_d = 8'(got + 1);
                n_cmp++; if (out_data !== exp_d) begin n_err++; $display("FAIL fill_drain_%0d got %h want %h", got, out_data, exp_d); end
                got++;
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (got !== 9) begin n_err++; $display("FAIL fill_drain_total got %0d want 9", got); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_drain_empty got %b want 1", empty); end
    endtask

    task automatic test_arbitration();
        logic [7:0] d = 8'h40;
        do_reset();
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp++; if (ram_cs !== 1'b1 || ram_rws !== ((c % 2) == 0)) begin n_err++; $display("FAIL arb_cycle_%0d got cs=%b rws=%b want cs=1 rws=%b", c, ram_cs, ram_rws, (c % 2) == 0); end
            if (in_ready) d = d + 8'd1;
            @(posedge clk); #1;
            in_data = d;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got = 0;
        do_reset();
        for (int c = 0; c < 400 && got < 20; c++) begin
            in_valid = (sent < 20);
            in_data = 8'(sent);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                n_cmp++; if (out_data !== 8'(got)) begin n_err++; $display("FAIL wrap_word_%0d got %h want %h", got, out_data, 8'(got)); end
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++; if (got !== 20) begin n_err++; $display("FAIL wrap_total got %0d want 20", got); end
        n_cmp++; if (ram_wptr !== 3'd4 || ram_rptr !== 3'd4) begin n_err++; $display("FAIL wrap_ptrs got w=%0d r=%0d want 4/4", ram_wptr, ram_rptr); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b want 1", empty); end
    endtask

    task automatic test_midreset();
        int seen = 0;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 30 && count != 4'd5; c++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h10 + c);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL midrst_prefill got %0d want 5", count); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_state got count=%0d v=%b want 0/0", count, out_valid); end
        n_cmp++; if (ram_wptr !== 3'd0 || ram_rptr !== 3'd0) begin n_err++; $display("FAIL midrst_ptrs got w=%0d r=%0d want 0/0", ram_wptr, ram_rptr); end
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            if (out_valid) begin
                seen = 1;
                n_cmp++; if (out_data !== 8'h3C) begin n_err++; $display("FAIL midrst_first_word got %h want 3c", out_data); end
            end else begin
                @(posedge clk); #1;
            end
        end
        if (seen == 0) begin n_cmp++; n_err++; $display("FAIL midrst_timeout got no out_valid want 3c"); end
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst_n = 1'b0;
        test_reset();
        @(posedge clk); #1;
        test_single();
        test_fill();
        test_arbitration();
        test_wrap();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ff_ctrl

// File: doc/ff_ctrl.md
# ff_ctrl

- Pointer, flag and handshake controller that sits directly upstream of the convolution stage's flip-flop RAM.
- Drives chip-select, read/write select, write/read pointers and write data; captures read data into a registered output stage.
- Turns the single-port RAM into a valid/ready FIFO feeding the convolution datapath.
- Only one RAM access (read or write) is issued per cycle; simultaneous demand is arbitrated round-robin.

## Interface
- DATA_WIDTH, 8, word width
- ADDR_WIDTH, 3, RAM address width
- DEPTH, 1 << ADDR_WIDTH, RAM entries (power of two by construction)

- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  upstream word available
- in_data  input  DATA_WIDTH  upstream word
- in_ready  output  1  word accepted this cycle (combinational, may depend on in_valid)
- out_valid  output  1  out_data holds a valid word
- out_data  output  DATA_WIDTH  registered output word
- out_ready  input  1  downstream consumes when out_valid && out_ready
- count  output  ADDR_WIDTH+1  words held (RAM occupancy + out_valid)
- full  output  1  RAM occupancy == DEPTH
- empty  output  1  count == 0
- ram_cs  output  1  RAM chip select
- ram_rws  output  1  1 = write, 0 = read
- ram_wptr  output  ADDR_WIDTH  write address
- ram_rptr  output  ADDR_WIDTH  read address
- ram_wdata  output  DATA_WIDTH  equals in_data
- ram_rdata  input  DATA_WIDTH  RAM read data, valid in the same cycle as a read access

## Operation
- State: wptr, rptr (ADDR_WIDTH each), occ (ADDR_WIDTH+1, RAM occupancy), out_valid, out_data, prio (0 = write preferred, 1 = read preferred).
- Requests (combinational):
  - wr_req = in_valid && occ < DEPTH
  - rd_req = occ > 0 && (!out_valid || out_ready)
- Grant:
  - Only one requester: it wins.
  - Both: the side indicated by prio wins.
  - Any grant sets prio to the opposite side at the next edge.
- Outputs from grants:
  - in_ready = wr_grant
  - ram_cs = wr_grant | rd_grant
  - ram_rws = wr_grant
  - ram_wptr = wptr; ram_rptr = rptr
- While rst_n is low, all grants are forced to 0, so ram_cs = 0 and in_ready = 0.
- On wr_grant: wptr += 1 (wraps mod DEPTH); occ += 1.
- On rd_grant: out_data <= ram_rdata; out_valid <= 1; rptr += 1 (wraps); occ -= 1.
- Consume without rd_grant (out_valid && out_ready): out_valid <= 0, out_data holds.
- Never both grants in one cycle, so occ changes by at most ±1 per cycle.
- count = occ + out_valid. Maximum is DEPTH+1; the width accommodates it.
- FIFO order is strict; no bypass path around the RAM.

## Timing
- Reset (rst_n low at an edge): wptr = rptr = 0, occ = 0, out_valid = 0, out_data = 0, prio = 0. Hence count = 0, empty = 1, full = 0.
- Latency: word accepted in cycle N, read in cycle N+1 at the earliest, out_valid high in cycle N+2.
- Steady streaming with both sides active alternates W, R, W, R, giving 0.5 word/cycle each way.
- full: in_ready = 0 regardless of in_valid.
- empty RAM with out_valid = 1 and out_ready = 1: out_valid drops next cycle.
- Reset mid-operation discards all contents; no stale word ever reappears on out_data with out_valid = 1.

## Structure
- Shared package holds the arbitration side encoding (PRIO_WR = 0, PRIO_RD = 1) and the default DATA_WIDTH / ADDR_WIDTH constants.
- One sub-module, ff_ptr:
  - Parameterised wrap-around pointer register with clk, rst_n, inc and ptr.
  - Instantiated twice, for wptr and rptr.
- occ, prio and the output stage live in ff_ctrl.

## Test plan
- Reset: hold rst_n low 2 cycles with in_valid = 1 -> in_ready = 0, ram_cs = 0, out_valid = 0, count = 0, empty = 1.
- Single word: push 0xA5 with out_ready = 1.
  - Cycle 0: ram_cs = 1, ram_rws = 1, wptr = 0.
  - Cycle 1: read, rptr = 0.
  - Cycle 2: out_valid = 1, out_data = 0xA5.
  - Then empty = 1.
- Fill (DEPTH = 8), out_ready = 0, offer 0x01..0x0A:
  - After settling, exactly 9 words are held: count = 9, full = 1, in_ready = 0.
  - Draining returns 0x01..0x09 in order.
- Arbitration: in_valid = 1 and out_ready = 1 continuously from reset -> first grant is a write, then grants alternate W, R, W, R; ram_cs stays high every cycle.
- Wrap: stream 0x00..0x13 (20 words) with random out_ready -> pointers wrap 7 -> 0; output sequence is identical to input with no loss or duplication.
- Mid-op reset: reach count = 5, pulse rst_n low 1 cycle -> next cycle count = 0, out_valid = 0, pointers = 0; the next pushed word 0x3C is the first to appear on out_data.
